// File: rtl/counter_t_flip_flop_pkg.sv
// Shared constants for the T flip-flop counter family.
package counter_t_flip_flop_pkg;

  // Default number of T flip-flop stages (and count width).
  localparam int unsigned DEFAULT_WIDTH = 3;

  // Legal bounds for the count width.
  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 32;

  // Toggle enable for stage k: the stage flips when counting is enabled and
  // every lower stage is already 1 (the carry into stage k).
  function automatic logic stage_toggle(input logic        en,
                                        input logic [31:0] lower_bits,
                                        input int unsigned k);
    logic carry;
    carry = en;
    for (int unsigned i = 0; i < k; i++) begin
      carry = carry & lower_bits[i];
    end
    return carry;
  endfunction

endpackage

// File: rtl/counter_t_flip_flop_t_ff.sv
// Single T flip-flop cell: synchronous active-high reset, toggles when t_i is high.
module t_ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Next state: toggle on t_i, otherwise hold.
  always_comb begin
    // NOTE: default assigned first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (t_i) begin
      q_d = ~q_q;
    end
  end

  // State register with synchronous reset taking priority over toggle.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so all flops update together on the edge.
    if (reset_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_t_flip_flop.sv
// Synchronous binary up-counter built from a chain of T flip-flop cells.
// Every cell shares clk_i; higher cells toggle when T_i is high and all lower
// bits are 1, which makes the whole chain a plain increment-by-one.
module counter_t_flip_flop
  import counter_t_flip_flop_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             T_i,
  output logic [WIDTH-1:0] Q_o
);

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] toggle;
  logic [31:0]      q_ext;

  // Zero-extended copy of the count so the enable helper sees a fixed width.
  always_comb begin
    q_ext              = '0;
    q_ext[WIDTH-1:0]   = q_bits;
  end

  // One T flip-flop per stage; the enable of each stage is the AND of T_i and
  // all lower bits, computed combinationally from the registered count.
  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    assign toggle[k] = stage_toggle(T_i, q_ext, k);

    t_ff u_t_ff (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .t_i     (toggle[k]),
      .q_o     (q_bits[k])
    );
  end

  // Count comes straight from the flops, so it is registered and glitch-free.
  assign Q_o = q_bits;

endmodule

// File: tb/tb_counter_t_flip_flop.sv
// Self-checking bench: directed vectors with literal expectations on a WIDTH=3
// and a WIDTH=4 counter, plus a modulo-arithmetic model compared every cycle.
module tb_counter_t_flip_flop;

  logic       clk;
  logic       rst3, t3;
  logic       rst4, t4;
  logic [2:0] q3;
  logic [3:0] q4;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Model state: count modulo 2^WIDTH, valid once a reset edge has been seen.
  int m3 = 0;
  int m4 = 0;
  bit v3 = 0;
  bit v4 = 0;

  counter_t_flip_flop #(.WIDTH(3)) dut3 (
    .clk_i   (clk),
    .reset_i (rst3),
    .T_i     (t3),
    .Q_o     (q3)
  );

  counter_t_flip_flop #(.WIDTH(4)) dut4 (
    .clk_i   (clk),
    .reset_i (rst4),
    .T_i     (t4),
    .Q_o     (q4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: reset clears, enable adds one modulo 2^WIDTH.
  always @(posedge clk) begin
    if (rst3) begin
      m3 = 0;
      v3 = 1;
    end else if (t3) begin
      m3 = (m3 + 1) % 8;
    end
    if (rst4) begin
      m4 = 0;
      v4 = 1;
    end else if (t4) begin
      m4 = (m4 + 1) % 16;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (v3) check("model_cmp_w3", 32'(q3), 32'(m3));
    if (v4) check("model_cmp_w4", 32'(q4), 32'(m4));
  end

  // Apply one edge to the WIDTH=3 counter and check the literal expectation.
  task automatic apply3(input logic r, input logic t, input int exp);
    @(negedge clk);
    rst3 = r;
    t3   = t;
    @(posedge clk);
    #1;
    check("w3_dut", 32'(q3), 32'(exp));
    check("w3_model", 32'(m3), 32'(exp));
  endtask

  task automatic apply4(input logic r, input logic t, input int exp);
    @(negedge clk);
    rst4 = r;
    t4   = t;
    @(posedge clk);
    #1;
    check("w4_dut", 32'(q4), 32'(exp));
    check("w4_model", 32'(m4), 32'(exp));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst3 = 1'b1;
    t3   = 1'b1;
    rst4 = 1'b1;
    t4   = 1'b0;

    // Reset held for two edges with enable high.
    apply3(1'b1, 1'b1, 0);
    apply3(1'b1, 1'b1, 0);

    // Full count with wrap: 1..7, 0, 1.
    begin
      int seq_full[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
      for (int i = 0; i < 9; i++) apply3(1'b0, 1'b1, seq_full[i]);
    end

    // Advance to 5, hold for 4 edges, then increment to 6.
    for (int i = 2; i <= 5; i++) apply3(1'b0, 1'b1, i);
    for (int i = 0; i < 4; i++) apply3(1'b0, 1'b0, 5);
    apply3(1'b0, 1'b1, 6);

    // Reset mid-count with enable high: reset wins, then count resumes.
    apply3(1'b1, 1'b1, 0);
    apply3(1'b0, 1'b1, 1);

    // Sparse enable from 0.
    apply3(1'b1, 1'b0, 0);
    begin
      logic sparse_t[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int   sparse_exp[6] = '{1, 1, 2, 3, 3, 4};
      for (int i = 0; i < 6; i++) apply3(1'b0, sparse_t[i], sparse_exp[i]);
    end
    apply3(1'b0, 1'b0, 4);

    // WIDTH=4: reset, then 16 enabled edges reach 15 and wrap to 0.
    apply4(1'b1, 1'b1, 0);
    for (int i = 1; i <= 16; i++) apply4(1'b0, 1'b1, i % 16);
    apply4(1'b0, 1'b1, 1);
    apply4(1'b0, 1'b0, 1);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
